// File: rtl/fetch_pkg.sv
// fetch_pkg: constants and the {pc, inst} entry shared by fetch and decode
package fetch_pkg;
  localparam int PC_W = 32;
  localparam int INST_W = 32;
  localparam logic [PC_W-1:0] RESET_ADDR_DEF = 32'hbfc00000;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fe_entry_t;
endpackage

// File: rtl/fe_inst_fifo.sv
// fe_inst_fifo: synchronous FIFO of fetch entries with push/pop/flush and occupancy count
module fe_inst_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_ADDR = RESET_ADDR_DEF
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  fe_entry_t                din,
  output fe_entry_t                dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] rd_ptr, wr_ptr;
  fe_entry_t mem [DEPTH];
  // entries reset so the empty-queue outputs read {RESET_ADDR, 0}
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '{pc: RESET_ADDR, inst: '0};
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  assign dout = mem[rd_ptr];
endmodule

// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: PC generation, redirect and prefetch queue in front of decode.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_queue_stage
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_ADDR = RESET_ADDR_DEF,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  output logic              inst_sram_en,
  output logic [PC_W-1:0]   inst_sram_addr,
  input  logic [INST_W-1:0] inst_sram_rdata,
  input  logic              br_valid,
  input  logic [PC_W-1:0]   br_target,
  input  logic              de_ready,
  output logic              fe_valid,
  output logic [PC_W-1:0]   fe_pc,
  output logic [INST_W-1:0] fe_inst
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [PC_W-1:0] pc, req_pc;
  logic inflight, kill, resp_valid, bypass, pop, push;
  logic [CW-1:0] count;
  logic [CW:0] credit;
  fe_entry_t head, resp;
  assign resp = '{pc: req_pc, inst: inst_sram_rdata};
  assign resp_valid = inflight && !kill && !br_valid;
`ifdef FETCH_BYPASS_EN
  assign bypass = resp_valid && count == '0;
`else
  assign bypass = 1'b0;
`endif
  assign fe_valid = count != '0 || bypass;
  assign {fe_pc, fe_inst} = bypass ? resp : head;
  assign pop = fe_valid && de_ready && !br_valid;
  assign push = resp_valid && !(bypass && de_ready);
  // credit counts queued plus in-flight entries, so a full queue can never be overrun
  assign credit = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign inst_sram_en = resetn && !br_valid && credit < (CW+1)'(DEPTH);
  assign inst_sram_addr = pc;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc <= RESET_ADDR;
      req_pc <= RESET_ADDR;
      inflight <= 1'b0;
      kill <= 1'b0;
    end else begin
      inflight <= inst_sram_en;
      kill <= br_valid;
      if (br_valid) pc <= {br_target[PC_W-1:2], 2'b00};
      else if (inst_sram_en) begin
        pc <= pc + 32'd4;
        req_pc <= pc;
      end
    end
  end
  fe_inst_fifo #(.DEPTH(DEPTH), .RESET_ADDR(RESET_ADDR)) u_fifo (
    .clk(clk),
    .resetn(resetn),
    .flush(br_valid),
    .push(push),
    .pop(pop && !bypass),
    .din(resp),
    .dout(head),
    .count(count)
  );
endmodule
